// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM capture block.
// Holds the measurement FSM state encoding and the timeout threshold helper.
package pwm_pkg;

   typedef enum logic [1:0] {
      S_WAIT  = 2'd0,
      S_MEAS  = 2'd1,
      S_STUCK = 2'd2
   } state_t;

   // Period count at which a missing rising edge is declared a timeout.
   function automatic int unsigned timeout_thresh(input int unsigned bw);
      return (32'd1 << bw) + 32'd1;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser for an asynchronous input.
// Also produces single-cycle rise/fall strobes from the synchronised level.
module sync_edge_detect #(
   parameter int sync_stages = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [sync_stages-1:0] r_sync;
   logic                   r_dly;
   logic                   w_lvl;

   assign w_lvl = r_sync[sync_stages-1];

   // Shift the raw input through the synchroniser chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[sync_stages-2:0], async_in};
      end
   end

   // One-cycle delayed copy of the synchronised level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dly <= 1'b0;
      end else begin
         r_dly <= w_lvl;
      end
   end

   assign sync_out = w_lvl;
   assign rise     = w_lvl & ~r_dly;
   assign fall     = ~w_lvl & r_dly;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures duty and period of an asynchronous PWM input.
// Results use the generator's duty/max_value encoding for loopback checks.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int bit_width   = 8,
   parameter int sync_stages = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 pwm_in,
   output logic [bit_width-1:0] duty_out,
   output logic [bit_width-1:0] max_value_out,
   output logic                 valid,
   output logic                 timeout
);

   localparam int CW = bit_width + 1;

   localparam logic [CW-1:0] TH =
      CW'(timeout_thresh(bit_width));

   localparam logic [bit_width-1:0] ALL1 =
      {bit_width{1'b1}};

   localparam logic [CW-1:0] ONE = CW'(1);

   state_t               r_state;
   logic [CW-1:0]        r_period_cnt;
   logic [CW-1:0]        r_high_cnt;
   logic [bit_width-1:0] r_duty;
   logic [bit_width-1:0] r_max;
   logic                 r_valid;
   logic                 r_timeout;

   logic                 w_pwm_s;
   logic                 w_rise;
   logic                 w_unused_fall;
   logic                 w_thresh;
   logic [CW-1:0]        w_per_m1;

   // Clamp a counter value into the result width.
   function automatic logic [bit_width-1:0] sat(
      input logic [CW-1:0] x
   );
      return x[bit_width] ? ALL1 : x[bit_width-1:0];
   endfunction

   sync_edge_detect #(
      .sync_stages(sync_stages)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_in(pwm_in),
      .sync_out(w_pwm_s),
      .rise    (w_rise),
      .fall    (w_unused_fall)
   );

   assign w_thresh = (r_period_cnt == TH);
   assign w_per_m1 = r_period_cnt - ONE;

   // Measurement FSM: counters, result registers and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_WAIT;
         r_period_cnt <= '0;
         r_high_cnt   <= '0;
         r_duty       <= '0;
         r_max        <= '0;
         r_valid      <= 1'b0;
         r_timeout    <= 1'b0;
      end else if (!en) begin
         r_state      <= S_WAIT;
         r_period_cnt <= '0;
         r_high_cnt   <= '0;
         r_valid      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            S_WAIT: begin
               if (w_rise) begin
                  r_period_cnt <= ONE;
                  r_high_cnt   <= ONE;
                  r_state      <= S_MEAS;
               end else if (w_thresh) begin
                  r_duty       <= w_pwm_s ? ALL1 : '0;
                  r_max        <= ALL1;
                  r_timeout    <= 1'b1;
                  r_valid      <= 1'b1;
                  r_period_cnt <= '0;
                  r_high_cnt   <= '0;
                  r_state      <= S_STUCK;
               end else begin
                  r_period_cnt <= r_period_cnt + ONE;
               end
            end
            S_MEAS: begin
               if (w_rise) begin
                  r_duty       <= sat(r_high_cnt);
                  r_max        <= sat(w_per_m1);
                  r_valid      <= 1'b1;
                  r_timeout    <= 1'b0;
                  r_period_cnt <= ONE;
                  r_high_cnt   <= ONE;
               end else if (w_thresh) begin
                  r_duty       <= w_pwm_s ? ALL1 : '0;
                  r_max        <= ALL1;
                  r_timeout    <= 1'b1;
                  r_valid      <= 1'b1;
                  r_period_cnt <= '0;
                  r_high_cnt   <= '0;
                  r_state      <= S_STUCK;
               end else begin
                  r_period_cnt <= r_period_cnt + ONE;
                  if (w_pwm_s) begin
                     r_high_cnt <= r_high_cnt + ONE;
                  end
               end
            end
            S_STUCK: begin
               if (w_rise) begin
                  r_period_cnt <= ONE;
                  r_high_cnt   <= ONE;
                  r_state      <= S_MEAS;
               end
            end
            default: begin
               r_state <= S_WAIT;
            end
         endcase
      end
   end

   assign duty_out      = r_duty;
   assign max_value_out = r_max;
   assign valid         = r_valid;
   assign timeout       = r_timeout;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized loopback bench for pwm_capture.
// A behavioural PWM generator drives the DUT; reports are checked against it.
module tb_pwm_capture;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       en     = 1'b0;
   logic       pwm_in = 1'b0;
   logic [7:0] duty_out;
   logic [7:0] max_value_out;
   logic       valid;
   logic       timeout;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   bit gen_on = 1'b0;
   bit lvl    = 1'b0;
   int gen_d, gen_m, gen_dn, gen_mn;
   int gen_cnt = 0;
   int rises   = 0;

   typedef struct {
      int         cyc;
      int         rises;
      logic [7:0] d;
      logic [7:0] m;
      logic       to;
   } rep_t;

   rep_t q[$];

   pwm_capture #(
      .bit_width  (8),
      .sync_stages(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .pwm_in       (pwm_in),
      .duty_out     (duty_out),
      .max_value_out(max_value_out),
      .valid        (valid),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference generator: high while count < duty, period max+1,
   // new settings take effect at the period boundary.
   always @(posedge clk) begin : gen_p
      logic nxt;
      #1;
      if (gen_on) begin
         if (gen_cnt >= gen_m) begin
            gen_cnt = 0;
            gen_d   = gen_dn;
            gen_m   = gen_mn;
         end else begin
            gen_cnt = gen_cnt + 1;
         end
         nxt = (gen_cnt < gen_d);
      end else begin
         nxt = lvl;
      end
      if (nxt && !pwm_in) rises = rises + 1;
      pwm_in = nxt;
   end

   always @(negedge clk) begin
      if (valid === 1'b1)
         q.push_back('{cyc, rises, duty_out,
                       max_value_out, timeout});
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reset, start generator so pwm_in is low at release.
   task automatic setup_gen(input int d, input int m);
      @(negedge clk);
      rst_n   = 1'b0;
      en      = 1'b1;
      gen_d   = d;
      gen_dn  = d;
      gen_m   = m;
      gen_mn  = m;
      gen_cnt = d - 1;
      gen_on  = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
   endtask

   task automatic test_reset();
      wait_cyc(2);
      tests++;
      if (duty_out !== 8'd0) begin
         fails++;
         $display("FAIL reset_duty: got %0d want 0", duty_out);
      end
      tests++;
      if (max_value_out !== 8'd0) begin
         fails++;
         $display("FAIL reset_max: got %0d want 0", max_value_out);
      end
      tests++;
      if (valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_valid: got %b want 0", valid);
      end
      tests++;
      if (timeout !== 1'b0) begin
         fails++;
         $display("FAIL reset_timeout: got %b want 0", timeout);
      end
   endtask

   task automatic test_loopback(input int d, input int m,
                                input int nper, input string nm);
      int r0, n, rs;
      setup_gen(d, m);
      r0 = rises;
      wait_cyc(nper * (m + 1) + m + 10);
      n  = q.size();
      rs = rises - r0;
      tests++;
      if (n < 1 || n > rs - 1 || n < rs - 2) begin
         fails++;
         $display("FAIL %s_count: got %0d valids want %0d..%0d",
                  nm, n, rs - 2, rs - 1);
      end
      if (n > 0) begin
         tests++;
         if (q[0].rises - r0 < 2) begin
            fails++;
            $display("FAIL %s_first: valid after %0d rises want >=2",
                     nm, q[0].rises - r0);
         end
      end
      for (int i = 0; i < n; i++) begin
         tests++;
         if (q[i].d !== 8'(d) || q[i].m !== 8'(m) ||
             q[i].to !== 1'b0) begin
            fails++;
            $display("FAIL %s_val[%0d]: got d=%0d m=%0d to=%b want d=%0d m=%0d to=0",
                     nm, i, q[i].d, q[i].m, q[i].to, d, m);
         end
         if (i > 0) begin
            tests++;
            if (q[i].cyc - q[i-1].cyc != m + 1) begin
               fails++;
               $display("FAIL %s_gap[%0d]: got %0d want %0d",
                        nm, i, q[i].cyc - q[i-1].cyc, m + 1);
            end
         end
      end
   endtask

   task automatic test_random();
      int m, d;
      for (int k = 0; k < 5; k++) begin
         m = $urandom_range(60, 2);
         d = $urandom_range(m, 1);
         test_loopback(d, m, 4, "rand");
      end
   endtask

   task automatic test_stuck(input bit l);
      int c0, dt;
      logic [7:0] exp_d;
      exp_d = l ? 8'hFF : 8'h00;
      @(negedge clk);
      rst_n  = 1'b0;
      en     = 1'b1;
      gen_on = 1'b0;
      lvl    = l;
      wait_cyc(3);
      rst_n = 1'b1;
      c0    = cyc;
      q.delete();
      wait_cyc(600);
      tests++;
      if (q.size() != 1) begin
         fails++;
         $display("FAIL stuck%0d_count: got %0d valids want 1",
                  l, q.size());
      end
      if (q.size() > 0) begin
         tests++;
         if (q[0].d !== exp_d || q[0].m !== 8'hFF ||
             q[0].to !== 1'b1) begin
            fails++;
            $display("FAIL stuck%0d_val: got d=%0d m=%0d to=%b want d=%0d m=255 to=1",
                     l, q[0].d, q[0].m, q[0].to, exp_d);
         end
         dt = q[0].cyc - c0;
         tests++;
         if (dt < 256 || dt > 262) begin
            fails++;
            $display("FAIL stuck%0d_time: got %0d want 256..262",
                     l, dt);
         end
      end
      tests++;
      if (timeout !== 1'b1) begin
         fails++;
         $display("FAIL stuck%0d_level: got %b want 1", l, timeout);
      end
   endtask

   task automatic test_recover();
      int r0;
      @(negedge clk);
      gen_d   = 64;
      gen_dn  = 64;
      gen_m   = 255;
      gen_mn  = 255;
      gen_cnt = 63;
      gen_on  = 1'b1;
      r0      = rises;
      q.delete();
      for (int i = 0; i < 300 && rises - r0 < 1; i++)
         @(negedge clk);
      wait_cyc(10);
      tests++;
      if (timeout !== 1'b1 || q.size() != 0) begin
         fails++;
         $display("FAIL recover_hold: got to=%b valids=%0d want to=1 valids=0",
                  timeout, q.size());
      end
      for (int i = 0; i < 300 && q.size() == 0; i++)
         @(negedge clk);
      tests++;
      if (q.size() == 0) begin
         fails++;
         $display("FAIL recover_wait: got no valid want one");
      end else if (q[0].d !== 8'd64 || q[0].m !== 8'd255 ||
                   q[0].to !== 1'b0 || timeout !== 1'b0) begin
         fails++;
         $display("FAIL recover_val: got d=%0d m=%0d to=%b want 64 255 0",
                  q[0].d, q[0].m, q[0].to);
      end
   endtask

   task automatic test_switch();
      setup_gen(64, 255);
      wait_cyc(2 * 256 + 20 + $urandom_range(255, 0));
      gen_dn = 128;
      q.delete();
      wait_cyc(4 * 256 + 10);
      tests++;
      if (q.size() < 3) begin
         fails++;
         $display("FAIL switch_count: got %0d want >=3", q.size());
      end
      if (q.size() > 0) begin
         tests++;
         if ((q[0].d !== 8'd64 && q[0].d !== 8'd128) ||
             q[0].m !== 8'd255) begin
            fails++;
            $display("FAIL switch_trans: got d=%0d m=%0d want 64|128 255",
                     q[0].d, q[0].m);
         end
      end
      for (int i = 1; i < q.size(); i++) begin
         tests++;
         if (q[i].d !== 8'd128 || q[i].m !== 8'd255 ||
             q[i].to !== 1'b0) begin
            fails++;
            $display("FAIL switch_val[%0d]: got d=%0d m=%0d want 128 255",
                     i, q[i].d, q[i].m);
         end
      end
   endtask

   task automatic test_async_reset();
      int d, r0, need;
      bit lr;
      d = $urandom_range(19, 1);
      setup_gen(d, 20);
      wait_cyc(60 + $urandom_range(20, 0));
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if (duty_out !== 8'd0 || max_value_out !== 8'd0 ||
          valid !== 1'b0 || timeout !== 1'b0) begin
         fails++;
         $display("FAIL areset_clear: got d=%0d m=%0d v=%b to=%b want all 0",
                  duty_out, max_value_out, valid, timeout);
      end
      wait_cyc(3);
      rst_n = 1'b1;
      lr    = pwm_in;
      r0    = rises;
      need  = lr ? 1 : 2;
      q.delete();
      wait_cyc(5 * 21 + 10);
      tests++;
      if (q.size() < 2) begin
         fails++;
         $display("FAIL areset_count: got %0d want >=2", q.size());
      end else begin
         tests++;
         if (q[0].rises - r0 < need) begin
            fails++;
            $display("FAIL areset_first: got %0d rises want >=%0d",
                     q[0].rises - r0, need);
         end
         tests++;
         if (q[1].d !== 8'(d) || q[1].m !== 8'd20) begin
            fails++;
            $display("FAIL areset_val: got d=%0d m=%0d want %0d 20",
                     q[1].d, q[1].m, d);
         end
      end
   endtask

   task automatic test_enable();
      int r0;
      setup_gen(10, 30);
      wait_cyc(100);
      en = 1'b0;
      wait_cyc(1);
      q.delete();
      wait_cyc(99);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL en_quiet: got %0d valids want 0", q.size());
      end
      tests++;
      if (duty_out !== 8'd10 || max_value_out !== 8'd30 ||
          timeout !== 1'b0) begin
         fails++;
         $display("FAIL en_hold: got d=%0d m=%0d to=%b want 10 30 0",
                  duty_out, max_value_out, timeout);
      end
      for (int i = 0; i < 40 && gen_cnt != 20; i++)
         @(negedge clk);
      en = 1'b1;
      r0 = rises;
      q.delete();
      wait_cyc(3 * 31 + 10);
      tests++;
      if (q.size() < 1) begin
         fails++;
         $display("FAIL en_resume: got no valid want >=1");
      end else begin
         tests++;
         if (q[0].rises - r0 < 2) begin
            fails++;
            $display("FAIL en_first: got %0d rises want >=2",
                     q[0].rises - r0);
         end
      end
      for (int i = 0; i < q.size(); i++) begin
         tests++;
         if (q[i].d !== 8'd10 || q[i].m !== 8'd30 ||
             q[i].to !== 1'b0) begin
            fails++;
            $display("FAIL en_val[%0d]: got d=%0d m=%0d want 10 30",
                     i, q[i].d, q[i].m);
         end
      end
   endtask

   initial begin
      test_reset();
      test_loopback(64, 255, 3, "lb64");
      test_loopback(1, 3, 8, "lb1_3");
      test_random();
      test_stuck(1'b0);
      test_recover();
      test_stuck(1'b1);
      test_switch();
      test_async_reset();
      test_enable();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
